// File: rtl/usbh_fifo_pkt.sv
// Show-ahead synchronous FIFO for the USB host data paths, with level/almost flags,
// sticky overflow/underflow errors and optional packet mode (commit/rollback).
module usbh_fifo_pkt #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 64,
   parameter int ADDR_W     = 6,
   parameter int AFULL_LVL  = 56,
   parameter int AEMPTY_LVL = 8,
   parameter int PKT_MODE   = 0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [WIDTH-1:0]  data_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic              flush_i,
   input  logic              commit_i,
   input  logic              rollback_i,
   output logic [WIDTH-1:0]  data_o,
   output logic              full_o,
   output logic              empty_o,
   output logic              almost_full_o,
   output logic              almost_empty_o,
   output logic [ADDR_W:0]   level_o,
   output logic              overflow_o,
   output logic              underflow_o
);

   localparam int               CNT_W      = ADDR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AFULL_CNT  = CNT_W'(AFULL_LVL);
   localparam logic [CNT_W-1:0] AEMPTY_CNT = CNT_W'(AEMPTY_LVL);
   localparam logic             PKT        = (PKT_MODE != 0);

   logic [WIDTH-1:0]  mem [DEPTH];

   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] cmt_ptr_q, cmt_ptr_d;
   logic [CNT_W-1:0]  used_q, used_d;
   logic [CNT_W-1:0]  level_q, level_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic              push_ok, pop_ok;

   // Acceptance is decided from registered flags only, so a pop cannot make room
   // for a same-cycle push when the FIFO is full.
   assign push_ok = push_i & ~full_o & ~(PKT & rollback_i);
   assign pop_ok  = pop_i & ~empty_o;

   always_comb begin
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      cmt_ptr_d   = cmt_ptr_q;
      used_d      = used_q;
      level_d     = level_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (flush_i) begin
         rd_ptr_d    = '0;
         wr_ptr_d    = '0;
         cmt_ptr_d   = '0;
         used_d      = '0;
         level_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (push_i & full_o)  overflow_d  = 1'b1;
         if (pop_i & empty_o)  underflow_d = 1'b1;
         if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
         if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
         used_d  = used_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
         level_d = level_q - CNT_W'(pop_ok);
         if (!PKT) begin
            cmt_ptr_d = wr_ptr_d;
            level_d   = used_d;
         end else if (rollback_i) begin
            // Uncommitted bytes vanish; only the same-cycle pop still counts.
            wr_ptr_d = cmt_ptr_q;
            used_d   = level_d;
         end else if (commit_i) begin
            cmt_ptr_d = wr_ptr_d;
            level_d   = used_d;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         cmt_ptr_q   <= '0;
         used_q      <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         cmt_ptr_q   <= cmt_ptr_d;
         used_q      <= used_d;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk_i) begin
      if (!flush_i && push_ok) mem[wr_ptr_q] <= data_i;
   end

   assign data_o         = mem[rd_ptr_q];
   assign full_o         = (used_q == FULL_CNT);
   assign almost_full_o  = (used_q >= AFULL_CNT);
   assign empty_o        = (level_q == '0);
   assign almost_empty_o = (level_q <= AEMPTY_CNT);
   assign level_o        = level_q;
   assign overflow_o     = overflow_q;
   assign underflow_o    = underflow_q;

endmodule
